// File: rtl/apb_info_pkg.sv
// Shared types and address map for the APB info completer.
// Holds the FSM state type, register offsets and the access error rule.
package apb_info_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    ACCESS
  } state_t;

  localparam logic [31:0] ADDR_NUMBER  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATE    = 32'h0000_0004;
  localparam logic [31:0] ADDR_SURNAME = 32'h0000_0008;
  localparam logic [31:0] ADDR_NAME    = 32'h0000_000C;
  localparam logic [31:0] ADDR_CNT     = 32'h0000_0010;

  // Misaligned, out of range (incl. upper bits) or write to the RO counter.
  function automatic logic bad_access(
    input logic [31:0] addr,
    input logic        wr
  );
    return (addr[1:0] != 2'b00) ||
           (addr > ADDR_CNT) ||
           (wr && (addr == ADDR_CNT));
  endfunction

endpackage

// File: rtl/apb_info_regfile.sv
// Info register storage, address/error decode and transfer counters.
// Updates happen only on a commit pulse from the bus FSM.
module apb_info_regfile
  import apb_info_pkg::*;
#(
  parameter logic [31:0] RST_NUMBER  = 32'h0,
  parameter logic [31:0] RST_DATE    = 32'h0,
  parameter logic [31:0] RST_SURNAME = 32'h0,
  parameter logic [31:0] RST_NAME    = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_commit,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [31:0] r_info [4];
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;
  logic [1:0]  w_idx;
  logic [31:0] w_rd;

  assign o_err = bad_access(i_addr, i_write);
  assign w_idx = i_addr[3:2];

  // Register writes and counter bumps on a successful transfer only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_info[0] <= RST_NUMBER;
      r_info[1] <= RST_DATE;
      r_info[2] <= RST_SURNAME;
      r_info[3] <= RST_NAME;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else if (i_commit && !o_err) begin
      if (i_write) begin
        r_info[w_idx] <= i_wdata;
        r_wr_cnt      <= r_wr_cnt + 16'd1;
      end else begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  // Read mux; counter word shows the values before this read counts.
  always_comb begin
    w_rd = '0;
    case (i_addr)
      ADDR_NUMBER:  w_rd = r_info[0];
      ADDR_DATE:    w_rd = r_info[1];
      ADDR_SURNAME: w_rd = r_info[2];
      ADDR_NAME:    w_rd = r_info[3];
      ADDR_CNT:     w_rd = {r_rd_cnt, r_wr_cnt};
      default:      w_rd = '0;
    endcase
    o_rdata = (o_err || i_write) ? 32'h0 : w_rd;
  end

endmodule

// File: rtl/apb_info_completer.sv
// APB completer for the info registers: bus FSM, wait-state counter
// and registered PREADY/PRDATA/PSLVERR driven on entry to ACCESS.
module apb_info_completer
  import apb_info_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RST_NUMBER  = 32'h0,
  parameter logic [31:0] RST_DATE    = 32'h0,
  parameter logic [31:0] RST_SURNAME = 32'h0,
  parameter logic [31:0] RST_NAME    = 32'h0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_cnt_nx;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_write;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_slverr;
  logic                w_start;
  logic                w_commit;
  logic [31:0]         w_addr;
  logic [31:0]         w_wdata;
  logic                w_write;
  logic [31:0]         w_rf_rdata;
  logic                w_rf_err;

  // A setup phase is accepted from IDLE or straight after ACCESS.
  assign w_start = PSEL && !PENABLE &&
                   ((r_state == IDLE) || (r_state == ACCESS));

  // The first PENABLE cycle (SETUP) already counts as a wait cycle;
  // with no wait states the setup phase leads directly into ACCESS.
  always_comb begin
    w_next   = r_state;
    w_cnt_nx = r_cnt;
    unique case (r_state)
      IDLE, ACCESS: begin
        w_next = IDLE;
        if (w_start) begin
          w_cnt_nx = WS;
          w_next   = (WS == '0) ? ACCESS : SETUP;
        end
      end
      SETUP, WAIT: begin
        if (!PSEL) begin
          w_next   = IDLE;
          w_cnt_nx = '0;
        end else if (PENABLE) begin
          if (r_cnt <= WAIT_W'(1)) begin
            w_next   = ACCESS;
            w_cnt_nx = '0;
          end else begin
            w_next   = WAIT;
            w_cnt_nx = r_cnt - WAIT_W'(1);
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_commit = (w_next == ACCESS);

  // With zero wait states the commit coincides with the setup edge.
  assign w_addr  = w_start ? PADDR  : r_addr;
  assign w_wdata = w_start ? PWDATA : r_wdata;
  assign w_write = w_start ? PWRITE : r_write;

  // FSM state and wait counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Transfer attributes are frozen at the setup phase.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_start) begin
      r_addr  <= PADDR;
      r_wdata <= PWDATA;
      r_write <= PWRITE;
    end
  end

  // Response outputs live for exactly the ACCESS cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      r_ready  <= w_commit;
      r_rdata  <= w_commit ? w_rf_rdata : 32'h0;
      r_slverr <= w_commit && w_rf_err;
    end
  end

  assign PREADY  = r_ready;
  assign PRDATA  = r_rdata;
  assign PSLVERR = r_slverr;

  apb_info_regfile #(
    .RST_NUMBER  (RST_NUMBER),
    .RST_DATE    (RST_DATE),
    .RST_SURNAME (RST_SURNAME),
    .RST_NAME    (RST_NAME)
  ) u_regfile (
    .i_clk    (PCLK),
    .i_rst    (PRESET),
    .i_commit (w_commit),
    .i_write  (w_write),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_rdata  (w_rf_rdata),
    .o_err    (w_rf_err)
  );

endmodule
